// File: rtl/axi_burst_checker.sv
// rtl/axi_burst_checker.sv - AXI4 write-then-readback burst self-test master
module axi_burst_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [7:0]            cfg_len,
    input  logic [7:0]            cfg_bursts,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  resp_err,
    output logic                  timeout_err,
    output logic                  cfg_err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int SIZE = $clog2(STRB_WIDTH);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHK, AW, W, B, AR, R, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r, addr, beat_addr;
    logic [7:0]            len_r, bursts_r, burst_cnt, beat;
    logic [DATA_WIDTH-1:0] seed_r, pattern;
    logic [TW-1:0]         tcnt;

    logic [15:0]           burst_bytes, chk_end;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic                  crosses, last_burst, last_beat, hs, r_bad;

    assign burst_bytes = ({8'd0, len_r} + 16'd1) << SIZE;
    assign addr_step   = ADDR_WIDTH'(burst_bytes);
    assign chk_end     = {4'd0, addr[11:0]} + burst_bytes;
    assign crosses     = chk_end > 16'd4096;
    assign last_burst  = (burst_cnt + 8'd1) == bursts_r;
    assign last_beat   = beat == len_r;
    assign hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
                (m_axi_bvalid && m_axi_bready) || (m_axi_arvalid && m_axi_arready) ||
                (m_axi_rvalid && m_axi_rready);
    // A reply carrying a foreign ID is treated as a protocol fault like a bad RESP.
    assign r_bad = (m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat) || (m_axi_rid != '0);

    assign m_axi_awid    = '0;
    assign m_axi_arid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_araddr  = addr;
    assign m_axi_awlen   = len_r;
    assign m_axi_arlen   = len_r;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_arburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = pattern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_r         <= '0;
            addr           <= '0;
            beat_addr      <= '0;
            len_r          <= '0;
            bursts_r       <= '0;
            burst_cnt      <= '0;
            beat           <= '0;
            seed_r         <= '0;
            pattern        <= '0;
            tcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            resp_err       <= 1'b0;
            timeout_err    <= 1'b0;
            cfg_err        <= 1'b0;
            m_axi_awvalid  <= 1'b0;
            m_axi_wvalid   <= 1'b0;
            m_axi_wlast    <= 1'b0;
            m_axi_bready   <= 1'b0;
            m_axi_arvalid  <= 1'b0;
            m_axi_rready   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base_r         <= cfg_base_addr;
                    addr           <= cfg_base_addr;
                    len_r          <= cfg_len;
                    bursts_r       <= cfg_bursts;
                    seed_r         <= cfg_seed;
                    burst_cnt      <= '0;
                    tcnt           <= '0;
                    busy           <= 1'b1;
                    pass           <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    resp_err       <= 1'b0;
                    timeout_err    <= 1'b0;
                    cfg_err        <= 1'b0;
                    state          <= CHK;
                end
                // Walks one burst per cycle so the whole region is vetted before any traffic.
                CHK: begin
                    if (bursts_r == 8'd0) begin
                        state <= DONE;
                    end else if (crosses) begin
                        cfg_err <= 1'b1;
                        state   <= DONE;
                    end else if (last_burst) begin
                        addr          <= base_r;
                        burst_cnt     <= '0;
                        pattern       <= seed_r;
                        m_axi_awvalid <= 1'b1;
                        state         <= AW;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                        addr      <= addr + addr_step;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= !(cfg_err || timeout_err || resp_err || (err_count != 16'd0));
                    state <= IDLE;
                end
                default: begin
                    if (!hs && tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err   <= 1'b1;
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_wlast   <= 1'b0;
                        m_axi_bready  <= 1'b0;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b0;
                        state         <= DONE;
                    end else begin
                        tcnt <= hs ? '0 : tcnt + 1'b1;
                        case (state)
                            AW: if (m_axi_awready) begin
                                m_axi_awvalid <= 1'b0;
                                m_axi_wvalid  <= 1'b1;
                                m_axi_wlast   <= (len_r == 8'd0);
                                beat          <= '0;
                                state         <= W;
                            end
                            W: if (m_axi_wready) begin
                                pattern <= pattern + DATA_WIDTH'(1);
                                beat    <= beat + 8'd1;
                                if (last_beat) begin
                                    m_axi_wvalid <= 1'b0;
                                    m_axi_wlast  <= 1'b0;
                                    m_axi_bready <= 1'b1;
                                    state        <= B;
                                end else begin
                                    m_axi_wlast <= (beat + 8'd1) == len_r;
                                end
                            end
                            B: if (m_axi_bvalid) begin
                                m_axi_bready <= 1'b0;
                                if (m_axi_bresp != 2'b00 || m_axi_bid != '0)
                                    resp_err <= 1'b1;
                                if (last_burst) begin
                                    burst_cnt     <= '0;
                                    addr          <= base_r;
                                    pattern       <= seed_r;
                                    m_axi_arvalid <= 1'b1;
                                    state         <= AR;
                                end else begin
                                    burst_cnt     <= burst_cnt + 8'd1;
                                    addr          <= addr + addr_step;
                                    m_axi_awvalid <= 1'b1;
                                    state         <= AW;
                                end
                            end
                            AR: if (m_axi_arready) begin
                                m_axi_arvalid <= 1'b0;
                                m_axi_rready  <= 1'b1;
                                beat          <= '0;
                                beat_addr     <= addr;
                                state         <= R;
                            end
                            R: if (m_axi_rvalid) begin
                                if (m_axi_rdata != pattern) begin
                                    if (err_count == 16'd0)
                                        first_err_addr <= beat_addr;
                                    if (err_count != 16'hFFFF)
                                        err_count <= err_count + 16'd1;
                                end
                                if (r_bad)
                                    resp_err <= 1'b1;
                                pattern   <= pattern + DATA_WIDTH'(1);
                                beat      <= beat + 8'd1;
                                beat_addr <= beat_addr + ADDR_WIDTH'(STRB_WIDTH);
                                if (last_beat) begin
                                    m_axi_rready <= 1'b0;
                                    if (last_burst) begin
                                        state <= DONE;
                                    end else begin
                                        burst_cnt     <= burst_cnt + 8'd1;
                                        addr          <= addr + addr_step;
                                        m_axi_arvalid <= 1'b1;
                                        state         <= AR;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
